// File: rtl/mul.sv
// Sequential shift-add multiply-accumulate: num = quotient*denom + remainder, one multiplier bit
// per clock. Also flags (quotient, denom, remainder) triples that no valid division could produce.
module mul #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   quotient,
    input  logic [N-1:0]   denom,
    input  logic [N-1:0]   remainder,
    output logic [2*N-1:0] num,
    output logic           rdy,
    output logic           invalid
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e         state_q, state_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rdy_q, rdy_d;
    logic           invalid_q, invalid_d;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        rdy_d     = rdy_q;
        invalid_d = invalid_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d   = {{N{1'b0}}, denom};
                    mplier_d  = quotient;
                    acc_d     = {{N{1'b0}}, remainder};
                    cnt_d     = '0;
                    rdy_d     = 1'b0;
                    invalid_d = (denom == '0) || (remainder >= denom);
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                // Max result is 2^2N - 2^N, so the 2N-bit sum cannot wrap.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StIdle;
                    rdy_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            invalid_q <= invalid_d;
        end
    end

    assign num     = acc_q;
    assign rdy     = rdy_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_mul.sv
// Randomised and directed bench for mul, checked every cycle against an arithmetic model of the
// expected result and completion time.
module tb_mul;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   quotient = '0;
    logic [N-1:0]   denom = '0;
    logic [N-1:0]   remainder = '0;
    logic [2*N-1:0] num;
    logic           rdy;
    logic           invalid;

    int vectors = 0;
    int miscompares = 0;

    mul #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .quotient (quotient),
        .denom    (denom),
        .remainder(remainder),
        .num      (num),
        .rdy      (rdy),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model: an accepted request completes N edges later with the arithmetic result.
    int edge_no = 0;
    bit m_busy = 1'b0;
    bit m_rdy = 1'b0;
    bit m_inv = 1'b0;
    int m_num = 0;
    int m_done = 0;
    int p_num = 0;
    bit p_inv = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_inv  <= 1'b0;
            m_num  <= 0;
        end else begin
            edge_no <= edge_no + 1;
            if (!m_busy && start) begin
                m_busy <= 1'b1;
                m_rdy  <= 1'b0;
                m_done <= edge_no + N;
                p_num  <= (int'(quotient) * int'(denom) + int'(remainder)) % (1 << (2 * N));
                p_inv  <= (denom == 0) || (int'(remainder) >= int'(denom));
            end else if (m_busy && edge_no == m_done) begin
                m_busy <= 1'b0;
                m_rdy  <= 1'b1;
                m_num  <= p_num;
                m_inv  <= p_inv;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rdy", int'(rdy), int'(m_rdy));
            if (m_rdy) begin
                chk("num", int'(num), m_num);
                chk("invalid", int'(invalid), int'(m_inv));
            end
        end
    end

    // Issue one request from idle; returns cycles from accept edge until rdy is seen.
    task automatic op(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r,
                      output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        quotient  = q;
        denom     = d;
        remainder = r;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        quotient  = N'($urandom);
        denom     = N'($urandom);
        remainder = N'($urandom);
        lat = 0;
        while (!rdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n;

        #1;
        chk("reset rdy", int'(rdy), 0);
        chk("reset invalid", int'(invalid), 0);
        chk("reset num", int'(num), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op(4'd7, 4'd13, 4'd5, lat);
        chk("first latency", lat, N);
        chk("7*13+5 num", int'(num), 'h60);
        chk("7*13+5 invalid", int'(invalid), 0);

        op(4'd15, 4'd15, 4'd14, lat);
        chk("15*15+14 num", int'(num), 'hEF);
        chk("15*15+14 invalid", int'(invalid), 0);

        op(4'd0, 4'd9, 4'd3, lat);
        chk("0*9+3 num", int'(num), 'h03);
        chk("0*9+3 invalid", int'(invalid), 0);

        op(4'd5, 4'd0, 4'd2, lat);
        chk("d=0 num", int'(num), 'h02);
        chk("d=0 invalid", int'(invalid), 1);

        op(4'd3, 4'd4, 4'd4, lat);
        chk("r>=d num", int'(num), 'h10);
        chk("r>=d invalid", int'(invalid), 1);

        // Start held high from mid-operation: ignored while busy, taken at first idle edge.
        @(negedge clk);
        quotient = 4'd2; denom = 4'd11; remainder = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        quotient = 4'd9; denom = 4'd6; remainder = 4'd1; start = 1'b1;
        lat = 1;
        while (!rdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("busy latency", lat, N);
        chk("busy first num", int'(num), 29);
        chk("busy first invalid", int'(invalid), 0);
        @(negedge clk);
        chk("second accepted rdy", int'(rdy), 0);
        start = 1'b0;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("second latency", n, N);
        chk("second num", int'(num), 55);

        // Reset mid-operation on an invalid triple.
        @(negedge clk);
        quotient = 4'd3; denom = 4'd4; remainder = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset rdy", int'(rdy), 0);
        chk("midreset num", int'(num), 0);
        chk("midreset invalid", int'(invalid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no rdy after reset", int'(rdy), 0);
        end
        op(4'd15, 4'd15, 4'd14, lat);
        chk("post-reset latency", lat, N);
        chk("post-reset num", int'(num), 'hEF);

        // Random traffic, including requests while busy.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            quotient  = N'($urandom);
            denom     = N'($urandom);
            remainder = N'($urandom);
        end
        @(negedge clk);
        start = 1'b0;

        // Round trip of every (dividend, divisor) pair through an ideal divider.
        for (int nn = 0; nn < 256; nn++) begin
            for (int d = 0; d < 16; d++) begin
                int q;
                int r;
                q = (d == 0) ? (nn >> 4) : nn / d;
                r = (d == 0) ? (nn & 15) : nn % d;
                op(N'(q), N'(d), N'(r), lat);
                if (d == 0) begin
                    chk("sweep d=0 invalid", int'(invalid), 1);
                end else if (q < 16) begin
                    chk("sweep round trip", int'(num), nn);
                    chk("sweep invalid", int'(invalid), 0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
